// File: rtl/division_unsigned_requester.sv
// Client-facing initiator for the start/ready divider: request accept -> start pulse -> wait -> respond.
// Latency: start one cycle after accept, response one cycle after divider ready; holds response until rsp_ready_i.
module division_unsigned_requester #(
  parameter int g_width   = 8,
  parameter int g_timeout = 32
) (
  input  logic               clk_i,
  input  logic               res_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [g_width-1:0] dividend_i,
  input  logic [g_width-1:0] divisor_i,
  output logic               div_start_o,
  input  logic               div_ready_i,
  output logic [g_width-1:0] div_dividend_o,
  output logic [g_width-1:0] div_divisor_o,
  input  logic [g_width-1:0] div_quotient_i,
  input  logic [g_width-1:0] div_remainder_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [g_width-1:0] quotient_o,
  output logic [g_width-1:0] remainder_o,
  output logic               err_div0_o,
  output logic               err_timeout_o,
  output logic               busy_o
);

  localparam int c_tw = (g_timeout > 1) ? $clog2(g_timeout) : 1;
  localparam logic [c_tw-1:0] c_tlast = c_tw'(g_timeout - 1);

  typedef enum logic [1:0] {
    st_idle,
    st_launch,
    st_wait_done,
    st_respond
  } state_t;

  typedef struct packed {
    logic [g_width-1:0] quotient;
    logic [g_width-1:0] remainder;
    logic               err_div0;
    logic               err_timeout;
  } rsp_t;

  typedef struct packed {
    logic [g_width-1:0] dividend;
    logic [g_width-1:0] divisor;
  } opnd_t;

  state_t          state_q, state_d;
  logic [c_tw-1:0] timer_q, timer_d;
  rsp_t            rsp_q, rsp_d;
  opnd_t           opnd_q, opnd_d;

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      state_q <= st_idle;
      timer_q <= '0;
      rsp_q   <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rsp_q   <= rsp_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rsp_d   = rsp_q;
    opnd_d  = opnd_q;
    case (state_q)
      st_idle: begin
        if (req_valid_i) begin
          opnd_d.dividend = dividend_i;
          opnd_d.divisor  = divisor_i;
          // Zero divisor is answered locally; the divider never sees it.
          if (divisor_i == '0) begin
            rsp_d.quotient    = '1;
            rsp_d.remainder   = dividend_i;
            rsp_d.err_div0    = 1'b1;
            rsp_d.err_timeout = 1'b0;
            state_d           = st_respond;
          end else begin
            rsp_d.err_div0    = 1'b0;
            rsp_d.err_timeout = 1'b0;
            state_d           = st_launch;
          end
        end
      end
      st_launch: begin
        timer_d = '0;
        state_d = st_wait_done;
      end
      st_wait_done: begin
        // A ready pulse on the timeout edge still delivers a good result.
        if (div_ready_i) begin
          rsp_d.quotient  = div_quotient_i;
          rsp_d.remainder = div_remainder_i;
          state_d         = st_respond;
        end else if (timer_q == c_tlast) begin
          rsp_d.quotient    = '0;
          rsp_d.remainder   = '0;
          rsp_d.err_timeout = 1'b1;
          state_d           = st_respond;
        end else begin
          timer_d = timer_q + c_tw'(1);
        end
      end
      st_respond: begin
        if (rsp_ready_i) begin
          state_d = st_idle;
        end
      end
      default: begin
        state_d = st_idle;
      end
    endcase
  end

  assign req_ready_o    = (state_q == st_idle);
  assign div_start_o    = (state_q == st_launch);
  assign rsp_valid_o    = (state_q == st_respond);
  assign busy_o         = (state_q != st_idle);
  assign div_dividend_o = opnd_q.dividend;
  assign div_divisor_o  = opnd_q.divisor;
  assign quotient_o     = rsp_q.quotient;
  assign remainder_o    = rsp_q.remainder;
  assign err_div0_o     = rsp_q.err_div0;
  assign err_timeout_o  = rsp_q.err_timeout;

endmodule

// File: tb/tb_division_unsigned_requester.sv
// Directed bench for division_unsigned_requester; inputs driven and outputs sampled on the falling edge.
module tb_division_unsigned_requester;

  logic       clk_i = 1'b0;
  logic       res_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [7:0] dividend_i = '0;
  logic [7:0] divisor_i = '0;
  logic       div_start_o;
  logic       div_ready_i = 1'b0;
  logic [7:0] div_dividend_o;
  logic [7:0] div_divisor_o;
  logic [7:0] div_quotient_i = '0;
  logic [7:0] div_remainder_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [7:0] quotient_o;
  logic [7:0] remainder_o;
  logic       err_div0_o;
  logic       err_timeout_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  division_unsigned_requester #(.g_width(8), .g_timeout(32)) dut (
    .clk_i          (clk_i),
    .res_i          (res_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .div_start_o    (div_start_o),
    .div_ready_i    (div_ready_i),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_quotient_i (div_quotient_i),
    .div_remainder_i(div_remainder_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .quotient_o     (quotient_o),
    .remainder_o    (remainder_o),
    .err_div0_o     (err_div0_o),
    .err_timeout_o  (err_timeout_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Present a request for exactly one accepting edge.
  task automatic do_req(input logic [7:0] a, input logic [7:0] b);
    req_valid_i = 1'b1;
    dividend_i  = a;
    divisor_i   = b;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic pulse_ready(input logic [7:0] q, input logic [7:0] r);
    div_ready_i     = 1'b1;
    div_quotient_i  = q;
    div_remainder_i = r;
    tick();
    div_ready_i     = 1'b0;
    div_quotient_i  = 8'hA5;
    div_remainder_i = 8'h5A;
  endtask

  task automatic finish_rsp();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    check("rst_req_ready", 32'(req_ready_o), 1);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_start", 32'(div_start_o), 0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check("rst_outs", {quotient_o, remainder_o, div_dividend_o, div_divisor_o}, 0);
    check("rst_errs", 32'({err_div0_o, err_timeout_o}), 0);
    res_i = 1'b1;
    tick();

    // Normal 100/7 with a 9-cycle divider
    do_req(8'd100, 8'd7);
    check("n_start", 32'(div_start_o), 1);
    check("n_opnd", 32'({div_dividend_o, div_divisor_o}), 32'h6407);
    check("n_req_ready", 32'(req_ready_o), 0);
    tick();
    check("n_start_once", 32'(div_start_o), 0);
    for (int i = 0; i < 7; i++) tick();
    check("n_wait_rsp", 32'(rsp_valid_o), 0);
    tick();
    pulse_ready(8'd14, 8'd2);
    check("n_rsp_valid", 32'(rsp_valid_o), 1);
    check("n_q", 32'(quotient_o), 14);
    check("n_r", 32'(remainder_o), 2);
    check("n_errs", 32'({err_div0_o, err_timeout_o}), 0);
    finish_rsp();
    check("n_idle", 32'({rsp_valid_o, req_ready_o, busy_o}), 32'b010);

    // Divide by zero
    do_req(8'd55, 8'd0);
    check("z_rsp_valid", 32'(rsp_valid_o), 1);
    check("z_no_start", 32'(div_start_o), 0);
    check("z_q", 32'(quotient_o), 32'hFF);
    check("z_r", 32'(remainder_o), 55);
    check("z_errs", 32'({err_div0_o, err_timeout_o}), 32'b10);
    finish_rsp();

    // Timeout: 32 cycles in wait_done
    do_req(8'd20, 8'd3);
    check("t_start", 32'(div_start_o), 1);
    tick();
    for (int i = 0; i < 31; i++) tick();
    check("t_not_yet", 32'({rsp_valid_o, busy_o}), 32'b01);
    tick();
    check("t_rsp_valid", 32'(rsp_valid_o), 1);
    check("t_qr", 32'({quotient_o, remainder_o}), 0);
    check("t_errs", 32'({err_div0_o, err_timeout_o}), 32'b01);

    // Backpressure: response held, new request waits
    req_valid_i = 1'b1;
    dividend_i  = 8'd9;
    divisor_i   = 8'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_hold", 32'({rsp_valid_o, req_ready_o, err_timeout_o, quotient_o}), 32'b101_00000000);
      check("b_opnd", 32'(div_dividend_o), 20);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("b_idle", 32'({rsp_valid_o, req_ready_o}), 32'b01);
    check("b_not_acc", 32'(div_dividend_o), 20);
    tick();
    req_valid_i = 1'b0;
    check("b_start2", 32'(div_start_o), 1);
    check("b_opnd2", 32'({div_dividend_o, div_divisor_o}), 32'h0902);
    tick();
    pulse_ready(8'd4, 8'd1);
    check("b_res", 32'({quotient_o, remainder_o, err_div0_o, err_timeout_o}), 32'h0401 << 2);
    finish_rsp();

    // Stale ready pulses in idle and launch
    pulse_ready(8'd99, 8'd99);
    check("s_idle_ign", 32'({busy_o, req_ready_o, quotient_o}), 32'h104);
    do_req(8'd50, 8'd5);
    pulse_ready(8'd99, 8'd99);
    check("s_launch_ign", 32'({rsp_valid_o, busy_o}), 32'b01);
    // Ready on the exact timeout edge (cycle 32 of wait_done)
    for (int i = 0; i < 31; i++) tick();
    check("s_pre", 32'(rsp_valid_o), 0);
    pulse_ready(8'd10, 8'd0);
    check("s_rsp_valid", 32'(rsp_valid_o), 1);
    check("s_res", 32'({quotient_o, remainder_o, err_div0_o, err_timeout_o}), 32'h0A00 << 2);
    finish_rsp();

    // Reset during wait_done, then a late ready from the old division
    do_req(8'd77, 8'd7);
    tick();
    tick();
    res_i = 1'b0;
    #1;
    check("r_async", 32'({busy_o, req_ready_o, quotient_o}), 32'h100);
    tick();
    res_i = 1'b1;
    pulse_ready(8'd11, 8'd0);
    check("r_flags", 32'({rsp_valid_o, busy_o, req_ready_o, div_start_o}), 32'b0010);
    check("r_outs", {quotient_o, remainder_o, div_dividend_o, div_divisor_o}, 0);
    check("r_errs", 32'({err_div0_o, err_timeout_o}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
